// File: rtl/serial_compare_ctrl.sv
// serial_compare_ctrl: sequenced unsigned magnitude comparator that walks two
// WIDTH-bit operands MSB-first through a single 2-bit L/E/G compare slice.
// Latency: accept cycle to first out_valid cycle is NS+1 clocks by default;
// k+1 clocks with early exit, where k is the deciding slice counted from the MSB.
// Backpressure: in_ready is low from accept until the result has been taken;
// the result and out_valid are held until out_ready is high.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand pair offered         in_ready   block can accept a pair
//   a, b       WIDTH-bit operands, captured on accept
//   out_valid  result valid                 out_ready  consumer takes the result
//   L, E, G    one-hot result: A<B, A==B, A>B (held until the next accept)
//   busy       high while comparing or holding a result
//
// Build option: SERIAL_COMPARE_EARLY_EXIT_EN
//   defined   - COMPARE stops at the first differing slice (data-dependent latency)
//   undefined - every compare visits all NS slices (fixed latency); the first
//               differing slice is remembered and later slices are ignored.
//   Result values are identical in both builds.
//
// WIDTH must be even and >= 2.

module serial_compare_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             L,
  output logic             E,
  output logic             G,
  output logic             busy
);

  localparam int NS = WIDTH / 2;
  // Slice counter needs at least one bit even when there is a single slice.
  localparam int CW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [CW-1:0]    r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_l;
  logic             r_e;
  logic             r_g;

`ifndef SERIAL_COMPARE_EARLY_EXIT_EN
  // Sticky record of the first differing slice. Kept separate from L/G so the
  // outputs do not change before the fixed schedule completes.
  logic             r_dec_l;
  logic             r_dec_g;
  logic             w_dec;
  assign w_dec = r_dec_l | r_dec_g;
`endif

  // The single 2-bit compare slice, always looking at the top of the shifters.
  logic [1:0] w_as;
  logic [1:0] w_bs;
  logic       w_gt;
  logic       w_lt;
  logic       w_last;

  assign w_as   = r_a_sh[WIDTH-1 -: 2];
  assign w_bs   = r_b_sh[WIDTH-1 -: 2];
  assign w_gt   = (w_as > w_bs);
  assign w_lt   = (w_as < w_bs);
  assign w_last = (r_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_l         <= 1'b0;
      r_e         <= 1'b0;
      r_g         <= 1'b0;
`ifndef SERIAL_COMPARE_EARLY_EXIT_EN
      r_dec_l     <= 1'b0;
      r_dec_g     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a_sh     <= a;
            r_b_sh     <= b;
            r_cnt      <= CNT_LAST;
            r_l        <= 1'b0;
            r_e        <= 1'b0;
            r_g        <= 1'b0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
`ifndef SERIAL_COMPARE_EARLY_EXIT_EN
            r_dec_l    <= 1'b0;
            r_dec_g    <= 1'b0;
`endif
            r_state    <= S_COMPARE;
          end
        end

        S_COMPARE: begin
`ifdef SERIAL_COMPARE_EARLY_EXIT_EN
          if (w_gt || w_lt || w_last) begin
            // Either this slice differs, or every slice matched.
            r_g         <= w_gt;
            r_l         <= w_lt;
            r_e         <= ~w_gt & ~w_lt;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_a_sh <= r_a_sh << 2;
            r_b_sh <= r_b_sh << 2;
            r_cnt  <= r_cnt - 1'b1;
          end
`else
          if (w_last) begin
            // An earlier decision wins; otherwise the last slice decides.
            r_l         <= r_dec_l | (~w_dec & w_lt);
            r_g         <= r_dec_g | (~w_dec & w_gt);
            r_e         <= ~w_dec & ~w_lt & ~w_gt;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            if (!w_dec) begin
              r_dec_l <= w_lt;
              r_dec_g <= w_gt;
            end
            r_a_sh <= r_a_sh << 2;
            r_b_sh <= r_b_sh << 2;
            r_cnt  <= r_cnt - 1'b1;
          end
`endif
        end

        S_DONE: begin
          // Result stays put until taken; L/E/G persist into IDLE.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign L         = r_l;
  assign E         = r_e;
  assign G         = r_g;

endmodule

// File: doc/serial_compare_ctrl.md
Name: serial_compare_ctrl

Overview:
- Sequenced magnitude comparator for two WIDTH-bit unsigned operands.
- Accepts an operand pair over a valid/ready handshake, then walks the operands MSB-first, 2 bits per cycle, using one 2-bit compare slice (L/E/G).
- Returns a one-hot L/E/G result over a second valid/ready handshake.
- Reuses a single small compare slice instead of a full-width combinational comparator; it is the control wrapper around that slice.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 2; number of slices NS = WIDTH/2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operand pair offered
- in_ready  output  1  block can accept an operand pair
- a  input  WIDTH  operand A, sampled on accept
- b  input  WIDTH  operand B, sampled on accept
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- L  output  1  A < B
- E  output  1  A == B
- G  output  1  A > B
- busy  output  1  high in COMPARE or DONE

Behaviour:
- Reset is asynchronous and active-high; it drives:
  - state = IDLE; in_ready = 1; out_valid = 0; L = E = G = 0; busy = 0.
  - Internal shift registers = 0; slice counter = 0.
- State IDLE:
  - in_ready = 1.
  - Accept occurs on the edge where in_valid && in_ready.
  - On accept: load a_sh <= a, b_sh <= b; cnt <= NS-1; clear L/E/G; go to COMPARE.
- State COMPARE (in_ready = 0, out_valid = 0). Each cycle, compare the top slice: as = a_sh[WIDTH-1:WIDTH-2], bs = b_sh[WIDTH-1:WIDTH-2].
  - as > bs: G <= 1; go to DONE.
  - as < bs: L <= 1; go to DONE.
  - as == bs and cnt == 0: E <= 1; go to DONE.
  - as == bs and cnt != 0: shift a_sh and b_sh left by 2 (zero fill); cnt <= cnt-1; stay in COMPARE.
- State DONE:
  - out_valid = 1; L/E/G held stable and exactly one-hot.
  - On out_valid && out_ready: go to IDLE, out_valid deasserts next cycle, L/E/G remain at last value until the next accept.
  - in_valid is ignored; in_ready = 0.
- Latency, counted from the accept edge to the first cycle out_valid is high: k+1 clocks, where k = the index (1..NS) of the deciding slice, counted from MSB.
  - Minimum is 2 clocks. Maximum is NS+1 clocks (equal operands, or a difference in the LSB slice).
- No back-to-back overlap: the next accept is possible in the cycle after result handoff (IDLE). Throughput is at most one result per k+2 clocks.
- Simultaneous events:
  - out_ready held high while entering DONE: the result is consumed in its first valid cycle.
  - in_valid held high through a result: no new accept until IDLE.
- Operand inputs may change freely after accept; only the captured copies are used.
- Reset asserted mid-COMPARE or in DONE:
  - Immediate return to the reset values; the in-flight result is discarded and no out_valid is produced.
- cnt width is clog2(NS), minimum 1 bit.
- WIDTH == 2: single compare cycle; the cnt == 0 path is always taken on equality.

Optional Feature:
- Macro: SERIAL_COMPARE_EARLY_EXIT_EN.
- Defined:
  - Behaviour as above; COMPARE exits on the first differing slice.
  - Latency is data-dependent (k+1).
- Undefined:
  - COMPARE always runs all NS slices. The first differing slice latches L or G in a sticky decided flag; later slices are ignored.
  - E is set only if no slice differed.
  - Latency is constant NS+1 clocks for every operand pair (timing-leak-free, fixed schedule).
  - Result values are identical in both builds.

Test Plan:
- WIDTH=8, a=0x5A, b=0x5A, out_ready=1 → E=1, L=0, G=0; out_valid rises 5 clocks after accept, high for 1 cycle; busy high for 5 cycles.
- a=0xC0, b=0x3F → G=1. Early-exit build: out_valid 2 clocks after accept. Non-early-exit build: 5 clocks after accept, still G=1.
- a=0x12, b=0x13 → L=1 decided on the last slice; out_valid 5 clocks after accept in both builds.
- a=0x01, b=0x80, out_ready held 0 for 3 cycles after out_valid → L=1 stays stable and out_valid stays high; in_ready=0 while in_valid=1 with a new pair; accept occurs only after handoff then IDLE.
- Accept a=0xFF, b=0x00; assert rst 2 clocks later for 1 cycle → out_valid never rises, L=E=G=0, in_ready=1 in the cycle after rst deasserts. A following pair a=0x00, b=0x00 gives E=1 normally.
- Back-to-back pairs (0x10, 0x20), (0x20, 0x10), (0x33, 0x33) with in_valid and out_ready held high → results L, G, E in order; each accept occurs exactly 1 cycle after the previous result handoff.
